hamming_knn_accel: RTL

HAMMING_KNN_ACCEL -- requirements
Module: hamming_knn_accel

---
 rtl/hamming_knn_pkg.sv | 26 ++
 rtl/hamming_knn_popcount32.sv | 15 +
 rtl/hamming_knn_accel.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/hamming_knn_pkg.sv
// Shared constants, FSM encoding and width helper for the Hamming k-NN accelerator.
package hamming_knn_pkg;

   // Address bank codes carried in addr[11:8]
   localparam logic [3:0] BANK_TEST = 4'h0;
   localparam logic [3:0] BANK_CTRL = 4'hF;

   // Byte offsets within the control bank
   localparam logic [7:0] OFF_CTRL     = 8'h00;
   localparam logic [7:0] OFF_STATUS   = 8'h04;
   localparam logic [7:0] OFF_MIN_DIST = 8'h08;
   localparam logic [7:0] OFF_MIN_IDX  = 8'h0C;
   localparam logic [7:0] OFF_DIST0    = 8'h10;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_FIN  = 2'd2
   } state_e;

   // Bits needed to hold a distance between two NWORDS x 32-bit vectors
   function automatic int unsigned dist_width(input int unsigned nwords);
      return $clog2(32 * nwords + 1);
   endfunction

endpackage

// File: rtl/hamming_knn_popcount32.sv
// Combinational population count of a 32-bit word.
module popcount32 (
   input  logic [31:0] data_i,
   output logic [5:0]  count_o
);

   // Sum the set bits of the input word
   always_comb begin
      count_o = '0;
      for (int unsigned i = 0; i < 32; i++) begin
         count_o = count_o + 6'(data_i[i]);
      end
   end

endmodule

// File: rtl/hamming_knn_accel.sv
// Hamming-distance nearest-neighbour accelerator with an ICB register interface.
module hamming_knn_accel
   import hamming_knn_pkg::*;
#(
   parameter int unsigned NWORDS = 37,
   parameter int unsigned NTRAIN = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [31:0] cmd_addr,
   input  logic        cmd_read,
   input  logic [31:0] cmd_wdata,
   input  logic [3:0]  cmd_wmask,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic        irq
);

   localparam int unsigned DW = dist_width(NWORDS);
   localparam int unsigned WW = (NWORDS > 1) ? $clog2(NWORDS) : 1;
   localparam int unsigned TW = (NTRAIN > 1) ? $clog2(NTRAIN) : 1;

   state_e          state_q, state_d;
   logic [WW-1:0]   w_q;
   logic [TW-1:0]   t_q;
   logic [DW-1:0]   acc_q;
   logic [DW-1:0]   min_dist_q;
   logic [TW-1:0]   min_idx_q;
   logic [DW-1:0]   dist_q [NTRAIN];
   logic            irq_en_q, done_q;
   logic            rsp_valid_q, rsp_err_q;
   logic [31:0]     rsp_rdata_q;
   logic [31:0]     test_mem_q  [NWORDS];
   logic [31:0]     train_mem_q [NTRAIN][NWORDS];

   logic            cmd_fire, busy, start_go;
   logic [3:0]      bank;
   logic [5:0]      widx;
   logic [7:0]      off;
   logic            is_test, is_train;
   logic [WW-1:0]   wsel;
   logic [TW-1:0]   tsel, dsel;
   logic [31:0]     rdata_d;
   logic            err_d, test_we, train_we, start_acc, irqen_we, done_clr;
   logic [31:0]     pc_in;
   logic [5:0]      pc;
   logic [DW-1:0]   sum;
   logic            last_w, last_t;
   logic            unused_bits;

   assign unused_bits = ^{cmd_wmask, cmd_addr[31:12], cmd_addr[1:0]};

   assign cmd_ready = !rsp_valid_q | rsp_ready;
   assign cmd_fire  = cmd_valid & cmd_ready;
   assign busy      = (state_q != S_IDLE);
   assign start_go  = cmd_fire & start_acc;
   assign irq       = done_q & irq_en_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rsp_rdata_q;
   assign rsp_err   = rsp_err_q;

   assign bank     = cmd_addr[11:8];
   assign widx     = cmd_addr[7:2];
   assign off      = {widx, 2'b00};
   assign is_test  = (bank == BANK_TEST);
   assign is_train = (bank != BANK_TEST) && (32'(bank) <= NTRAIN);
   assign wsel     = WW'(widx);
   assign tsel     = TW'(bank - 4'd1);
   assign dsel     = TW'(widx - 6'd4);

   assign pc_in  = test_mem_q[w_q] ^ train_mem_q[t_q][w_q];
   assign sum    = acc_q + DW'(pc);
   assign last_w = (w_q == WW'(NWORDS - 1));
   assign last_t = (t_q == TW'(NTRAIN - 1));

   popcount32 u_popcount (
      .data_i  (pc_in),
      .count_o (pc)
   );

   // Address decode: read data, error flag and write side effects of the command
   always_comb begin
      rdata_d   = '0;
      err_d     = 1'b0;
      test_we   = 1'b0;
      train_we  = 1'b0;
      start_acc = 1'b0;
      irqen_we  = 1'b0;
      done_clr  = 1'b0;
      if (is_test || is_train) begin
         if (32'(widx) >= NWORDS) err_d = 1'b1;
         else if (cmd_read) rdata_d = is_test ? test_mem_q[wsel] : train_mem_q[tsel][wsel];
         else if (busy) err_d = 1'b1;
         else begin
            test_we  = is_test;
            train_we = is_train;
         end
      end else if (bank == BANK_CTRL) begin
         if (off == OFF_CTRL) begin
            if (cmd_read) rdata_d = {30'd0, irq_en_q, 1'b0};
            else begin
               irqen_we = 1'b1;
               if (cmd_wdata[0]) begin
                  if (busy) err_d = 1'b1;
                  else start_acc = 1'b1;
               end
            end
         end else if (off == OFF_STATUS) begin
            if (cmd_read) rdata_d = {30'd0, done_q, busy};
            else done_clr = cmd_wdata[1];
         end else if (off == OFF_MIN_DIST) begin
            if (cmd_read) rdata_d = 32'(min_dist_q);
         end else if (off == OFF_MIN_IDX) begin
            if (cmd_read) rdata_d = 32'(min_idx_q);
         end else if (32'(off) >= 32'(OFF_DIST0) && 32'(off) < 32'(OFF_DIST0) + 4 * NTRAIN) begin
            if (cmd_read) rdata_d = 32'(dist_q[dsel]);
         end else begin
            err_d = 1'b1;
         end
      end else begin
         err_d = 1'b1;
      end
   end

   // FSM next state
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (start_go) state_d = S_RUN;
         S_RUN:   if (last_w && last_t) state_d = S_FIN;
         S_FIN:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   // Distance accumulation, result registers and control bits
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         w_q        <= '0;
         t_q        <= '0;
         acc_q      <= '0;
         min_dist_q <= '1;
         min_idx_q  <= '0;
         irq_en_q   <= 1'b0;
         done_q     <= 1'b0;
         for (int unsigned j = 0; j < NTRAIN; j++) dist_q[j] <= '0;
      end else begin
         if (cmd_fire && irqen_we) irq_en_q <= cmd_wdata[1];
         // a completing run wins over a same-cycle W1C
         if (state_q == S_FIN) done_q <= 1'b1;
         else if (start_go || (cmd_fire && done_clr)) done_q <= 1'b0;
         if (state_q == S_RUN) begin
            if (last_w) begin
               dist_q[t_q] <= sum;
               acc_q       <= '0;
               w_q         <= '0;
               t_q         <= last_t ? '0 : t_q + TW'(1);
               if (t_q == '0 || sum < min_dist_q) begin
                  min_dist_q <= sum;
                  min_idx_q  <= t_q;
               end
            end else begin
               acc_q <= sum;
               w_q   <= w_q + WW'(1);
            end
         end
      end
   end

   // Registered response channel, held until accepted
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
      end else if (cmd_fire) begin
         rsp_valid_q <= 1'b1;
         rsp_rdata_q <= rdata_d;
         rsp_err_q   <= err_d;
      end else if (rsp_ready) begin
         rsp_valid_q <= 1'b0;
      end
   end

   // Vector buffers; deliberately not reset so contents survive a reset
   always_ff @(posedge clk) begin
      if (cmd_fire && test_we)  test_mem_q[wsel] <= cmd_wdata;
      if (cmd_fire && train_we) train_mem_q[tsel][wsel] <= cmd_wdata;
   end

endmodule
